// File: rtl/token_multiplier.sv
// token_multiplier: expands each input token on 'a' into FACTOR output
// tokens on 'b', with downstream back-pressure via b_ready. Tokens owed
// but not yet emitted accumulate in a saturating backlog counter; hitting
// the ceiling sets a sticky overflow flag.
//
// Optional feature: define TOKEN_MULT_FLUSH_EN to add a 'flush' input that
// discards the backlog (overflow is left untouched).
module token_multiplier #(
  parameter int FACTOR  = 2,
  parameter int MAX_RUN = 200
) (
  input  logic clk,
  input  logic rst,
`ifdef TOKEN_MULT_FLUSH_EN
  input  logic flush,
`endif
  input  logic a,
  input  logic b_ready,
  output logic b,
  output logic overflow,
  output logic busy
);

  // Backlog ceiling: the longest accepted run leaves (FACTOR-1) tokens
  // owed per input token when the output drains one per cycle.
  localparam int CAP   = (FACTOR - 1) * MAX_RUN;
  localparam int CNT_W = $clog2(CAP + 1);
  // Extra headroom so the unclamped next value can never wrap.
  localparam int EXT_W = CNT_W + 5;

  logic [CNT_W-1:0] p;
  logic [EXT_W-1:0] p_next_ext;
  logic             flush_i;

`ifdef TOKEN_MULT_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Emit a token whenever downstream is ready and there is something to
  // send: either a fresh input token or an owed one. Flush suppresses it.
  assign b = b_ready & (a | (p != '0)) & ~flush_i;

  assign busy = (p != '0);

  // Unclamped next backlog; b implies a or p>0, so this never underflows.
  always_comb begin
    p_next_ext = EXT_W'(p)
               + (a ? EXT_W'(FACTOR) : '0)
               - EXT_W'(b);
  end

  // Backlog counter and sticky overflow flag, with reset taking priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      p        <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      p <= '0;
    end else if (p_next_ext > EXT_W'(CAP)) begin
      p        <= CNT_W'(CAP);
      overflow <= 1'b1;
    end else begin
      p <= p_next_ext[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_token_multiplier.sv
// Directed self-checking bench for token_multiplier. Two instances share
// the stimulus: FACTOR=2 and FACTOR=3, both with MAX_RUN=200.
module tb_token_multiplier;

  logic clk = 1'b0;
  logic rst;
  logic a;
  logic b_ready;
  logic flush;
  logic b2, ovf2, busy2;
  logic b3, ovf3, busy3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  token_multiplier #(.FACTOR(2), .MAX_RUN(200)) dut2 (
    .clk(clk), .rst(rst),
`ifdef TOKEN_MULT_FLUSH_EN
    .flush(flush),
`endif
    .a(a), .b_ready(b_ready), .b(b2), .overflow(ovf2), .busy(busy2)
  );

  token_multiplier #(.FACTOR(3), .MAX_RUN(200)) dut3 (
    .clk(clk), .rst(rst),
`ifdef TOKEN_MULT_FLUSH_EN
    .flush(flush),
`endif
    .a(a), .b_ready(b_ready), .b(b3), .overflow(ovf3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs at a falling edge and let combinational outputs settle.
  task automatic drive(input logic av, input logic rv);
    a       = av;
    b_ready = rv;
    #1;
  endtask

  // Synchronous reset pulse; returns at a falling edge after the reset edge.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; a = 1'b0; b_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [25:0] a_vec;
    logic [25:0] b_vec;
    int ones;

    rst = 1'b1; a = 1'b0; b_ready = 1'b0; flush = 1'b0;
    reset_dut();

    // Reset state: empty backlog, no overflow, b follows b_ready & a.
    check("rst_busy2", busy2, 0);
    check("rst_ovf2", ovf2, 0);
    check("rst_busy3", busy3, 0);
    drive(1'b0, 1'b1);
    check("rst_b_idle", b2, 0);
    drive(1'b1, 1'b1);
    check("rst_b_pass", b2, 1);

    // FACTOR=2 doubling with b_ready held high.
    reset_dut();
    a_vec = 26'b10010011000110100001100100;
    b_vec = 26'b11011011110111111001111110;
    for (int i = 25; i >= 0; i--) begin
      drive(a_vec[i], 1'b1);
      check($sformatf("dbl_b[%0d]", 25 - i), b2, b_vec[i]);
      @(negedge clk);
    end
    check("dbl_ovf", ovf2, 0);
    check("dbl_busy", busy2, 0);

    // FACTOR=3: one token gives three outputs; busy for exactly two cycles.
    reset_dut();
    drive(1'b1, 1'b1);
    check("f3_b0", b3, 1);
    @(negedge clk);
    check("f3_busy0", busy3, 1);
    drive(1'b0, 1'b1);
    check("f3_b1", b3, 1);
    @(negedge clk);
    check("f3_busy1", busy3, 1);
    drive(1'b0, 1'b1);
    check("f3_b2", b3, 1);
    @(negedge clk);
    check("f3_busy2", busy3, 0);
    drive(1'b0, 1'b1);
    check("f3_b3", b3, 0);
    @(negedge clk);
    check("f3_busy3", busy3, 0);

    // Run of exactly MAX_RUN ones: 400 outputs, no overflow.
    reset_dut();
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b1);
      ones += int'(b2);
      @(negedge clk);
    end
    check("run200_ovf_mid", ovf2, 0);
    for (int i = 0; i < 250; i++) begin
      drive(1'b0, 1'b1);
      ones += int'(b2);
      @(negedge clk);
    end
    check("run200_ones", ones, 400);
    check("run200_ovf", ovf2, 0);
    check("run200_busy", busy2, 0);

    // Run of MAX_RUN+1: overflow rises on the 201st token edge and sticks.
    reset_dut();
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b1);
      ones += int'(b2);
      @(negedge clk);
    end
    check("run201_ovf_at200", ovf2, 0);
    drive(1'b1, 1'b1);
    ones += int'(b2);
    @(negedge clk);
    check("run201_ovf_at201", ovf2, 1);
    for (int i = 0; i < 250; i++) begin
      drive(1'b0, 1'b1);
      ones += int'(b2);
      @(negedge clk);
    end
    check("run201_ones", ones, 401);
    check("run201_ovf_sticky", ovf2, 1);
    check("run201_busy", busy2, 0);
    reset_dut();
    check("run201_ovf_clr", ovf2, 0);

    // Back-pressure: three tokens held, then six drained.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      check($sformatf("bp_hold_b[%0d]", i), b2, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1);
      check($sformatf("bp_drain_b[%0d]", i), b2, (i < 6) ? 1 : 0);
      @(negedge clk);
    end
    check("bp_busy", busy2, 0);

    // Reset mid-operation with backlog 5 and overflow set.
    reset_dut();
    for (int i = 0; i < 101; i++) begin
      drive(1'b1, 1'b0);
      @(negedge clk);
    end
    check("mid_ovf_set", ovf2, 1);
    for (int i = 0; i < 195; i++) begin
      drive(1'b0, 1'b1);
      @(negedge clk);
    end
    check("mid_busy_p5", busy2, 1);
    check("mid_ovf_held", ovf2, 1);
    rst = 1'b1;
    drive(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy2, 0);
    check("mid_rst_ovf", ovf2, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1);
      check($sformatf("mid_rst_b[%0d]", i), b2, 0);
      @(negedge clk);
    end

`ifdef TOKEN_MULT_FLUSH_EN
    // Flush with backlog 4 and a=1: b forced low, backlog cleared.
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0);
      @(negedge clk);
    end
    check("fl_busy_pre", busy2, 1);
    flush = 1'b1;
    drive(1'b1, 1'b1);
    check("fl_b", b2, 0);
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy", busy2, 0);
    check("fl_ovf", ovf2, 0);
    drive(1'b0, 1'b1);
    check("fl_b_after", b2, 0);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/token_multiplier.md
TOKEN_MULTIPLIER -- requirements
Module: token_multiplier

Interface
REQ-001 The block SHALL provide parameter FACTOR, default 2, giving the output tokens per input token; legal range 2..16.
REQ-002 The block SHALL provide parameter MAX_RUN, default 200, giving the longest back-to-back run of input '1' tokens accepted with b_ready held high; legal range 1..4095.
REQ-003 The block SHALL derive CAP = (FACTOR-1)*MAX_RUN and CNT_W = $clog2(CAP+1) internally; neither SHALL be a port or an overridable parameter.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 a  input  1  serial token stream; a='1' in a cycle is one input token.
REQ-007 b_ready  input  1  downstream accepts an output token this cycle.
REQ-008 b  output  1  serial output token stream, combinational.
REQ-009 overflow  output  1  sticky error flag, registered.
REQ-010 busy  output  1  pending backlog is non-zero, derived from registered state.

Function
REQ-011 The block SHALL hold a pending counter P, CNT_W bits wide, counting output tokens owed but not yet emitted.
REQ-012 Output b SHALL equal b_ready AND (a OR P!=0) in the same cycle, with zero-cycle latency from a.
REQ-013 The next value of P SHALL be computed as Pn = P + (a ? FACTOR : 0) - (b ? 1 : 0), evaluated at CNT_W+5 bits without wrap.
REQ-014 If Pn <= CAP, then P SHALL load Pn.
REQ-015 If Pn > CAP, then P SHALL load CAP, excess tokens SHALL be dropped, and overflow SHALL be set on the same edge.
REQ-016 Once set, overflow SHALL remain high until rst, regardless of a, b_ready or P.
REQ-017 After overflow the block SHALL continue normal emission and counting.
REQ-018 busy SHALL equal P!=0.
REQ-019 With b_ready held '0', b SHALL be '0' and P SHALL grow by FACTOR per input token, still subject to REQ-015.
REQ-020 With FACTOR=2 and b_ready held '1', the block SHALL reproduce the doubling behaviour: each '1' SHALL be output as two '1's, and runs are stretched by their own length.
REQ-021 P SHALL never underflow; b can be '1' only when a='1' or P>0.

Reset
REQ-022 While rst is high at a rising edge, P SHALL load 0 and overflow SHALL load 0; consequently busy=0 and b = b_ready AND a.
REQ-023 rst SHALL take priority over all other inputs, including a mid-run or while overflow is set.
REQ-024 Pending tokens at reset SHALL be discarded and SHALL never be emitted.

Configuration
REQ-025 With macro TOKEN_MULT_FLUSH_EN defined, the block SHALL add port flush (input, 1 bit).
REQ-026 While flush=1 at an edge, P SHALL load 0, b SHALL be forced '0' that cycle, and a SHALL be ignored that cycle.
REQ-027 flush SHALL NOT clear overflow.
REQ-028 If rst and flush are both high, rst SHALL govern.
REQ-029 With TOKEN_MULT_FLUSH_EN undefined, the flush port and its logic SHALL be absent and behaviour SHALL be exactly REQ-011..REQ-024.

Verification
REQ-030 FACTOR=2, b_ready=1: a=10010011000110100001100100 -> b=11011011110111111001111110; overflow stays 0.
REQ-031 FACTOR=3, b_ready=1: single a=1 followed by zeros -> b=111 then 0; busy high for exactly 2 cycles.
REQ-032 FACTOR=2, MAX_RUN=200: run of 200 ones then zeros -> 400 ones on b, overflow stays 0. A run of 201 -> overflow=1 from the edge of the 201st token, held after a=0 until rst.
REQ-033 FACTOR=2, b_ready=0 for 3 cycles with a=1, then b_ready=1 and a=0 -> b=000 then 6 ones then 0; P peaks at 6.
REQ-034 Reset mid-operation: with P=5 and overflow=1, assert rst for 1 cycle -> P=0, overflow=0, busy=0 next cycle, and no further b pulses.
REQ-035 TOKEN_MULT_FLUSH_EN defined: with P=4, pulse flush for 1 cycle with a=1 -> b=0 that cycle, P=0 afterward, overflow unchanged.
